// File: rtl/demux_sched.sv
// 1-to-4 stream demultiplexer scheduler with round-robin or directed steering and a flush/drain FSM.
// Optional macro DEMUX_SCHED_SKIP_EN: round-robin skips stalled lanes and picks the first free one from ptr.
module demux_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_dest,
  input  logic             mode,
  input  logic             flush,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             rdy0,
  input  logic             rdy1,
  input  logic             rdy2,
  input  logic             rdy3,
  output logic             busy
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] y_q [4];
  logic [3:0]       v_q;
  logic [1:0]       ptr;
  logic [3:0]       rdy_v;
  logic [3:0]       lane_free;
  logic [1:0]       rr_target;
  logic [1:0]       target;
  logic             take;

  assign rdy_v     = {rdy3, rdy2, rdy1, rdy0};
  // A lane is free if empty or its word leaves this cycle, allowing one-word-per-cycle pass-through.
  assign lane_free = ~v_q | rdy_v;

`ifdef DEMUX_SCHED_SKIP_EN
  logic       found;
  logic [1:0] cand;
  always_comb begin
    rr_target = ptr;
    found     = 1'b0;
    cand      = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && lane_free[cand]) begin
        rr_target = cand;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    rr_target = ptr;
  end
`endif

  assign target   = mode ? in_dest : rr_target;
  assign sel      = target;
  assign in_ready = (state == RUN) && lane_free[target];
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        y_q[i] <= '0;
      end
      v_q   <= '0;
      ptr   <= '0;
      state <= RUN;
      busy  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (take && (target == i[1:0])) begin
          y_q[i] <= din;
          v_q[i] <= 1'b1;
        end else if (v_q[i] && rdy_v[i]) begin
          v_q[i] <= 1'b0;
        end
      end
      case (state)
        RUN: begin
          if (take && !mode) begin
            ptr <= target + 2'd1;
          end
          if (flush) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (v_q == 4'b0000) begin
            state <= RUN;
            busy  <= 1'b0;
            ptr   <= '0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];
  assign v0 = v_q[0];
  assign v1 = v_q[1];
  assign v2 = v_q[2];
  assign v3 = v_q[3];

endmodule

// File: tb/tb_demux_sched.sv
// Self-checking bench for demux_sched: directed vector table, hand-written corner sequences,
// and randomized traffic against a lane-array reference model.
module tb_demux_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_dest;
  logic       mode;
  logic       flush;
  logic [1:0] sel;
  logic [7:0] y0, y1, y2, y3;
  logic       v0, v1, v2, v3;
  logic [3:0] rdy;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .mode(mode), .flush(flush), .sel(sel),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .rdy0(rdy[0]), .rdy1(rdy[1]), .rdy2(rdy[2]), .rdy3(rdy[3]),
    .busy(busy)
  );

  // Reference model: four lane slots, a pointer and a draining flag.
  bit [7:0] m_y [4];
  bit       m_v [4];
  int       m_ptr;
  bit       m_drain;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_y[i] = 8'h00;
      m_v[i] = 1'b0;
    end
    m_ptr   = 0;
    m_drain = 1'b0;
  endtask

  function automatic int m_target();
    if (mode) return int'(in_dest);
`ifdef DEMUX_SCHED_SKIP_EN
    for (int k = 0; k < 4; k++) begin
      int l = (m_ptr + k) % 4;
      if (!m_v[l] || rdy[l]) return l;
    end
`endif
    return m_ptr;
  endfunction

  function automatic bit m_ready();
    int t = m_target();
    return !m_drain && (!m_v[t] || rdy[t]);
  endfunction

  task automatic model_check();
    int t = m_target();
    chk("sel", 32'(sel), 32'(t));
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("busy", 32'(busy), 32'(m_drain));
    chk("valids", 32'({v3, v2, v1, v0}), 32'({m_v[3], m_v[2], m_v[1], m_v[0]}));
    chk("lane_data", {y3, y2, y1, y0}, {m_y[3], m_y[2], m_y[1], m_y[0]});
  endtask

  task automatic model_step();
    int t     = m_target();
    bit acc   = in_valid && m_ready();
    bit empty = !(m_v[0] || m_v[1] || m_v[2] || m_v[3]);
    for (int l = 0; l < 4; l++) begin
      if (acc && l == t) begin
        m_y[l] = din;
        m_v[l] = 1'b1;
      end else if (m_v[l] && rdy[l]) begin
        m_v[l] = 1'b0;
      end
    end
    if (!m_drain) begin
      if (acc && !mode) m_ptr = (t + 1) % 4;
      if (flush) m_drain = 1'b1;
    end else if (empty) begin
      m_drain = 1'b0;
      m_ptr   = 0;
    end
  endtask

  task automatic drive(input bit vld, input bit md, input bit [1:0] dst, input bit [7:0] d,
                       input bit [3:0] r, input bit fl);
    @(negedge clk);
    in_valid = vld;
    mode     = md;
    in_dest  = dst;
    din      = d;
    rdy      = r;
    flush    = fl;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    bit       vld;
    bit       md;
    bit [1:0] dst;
    bit [7:0] d;
    bit [3:0] r;
    bit       fl;
    bit       ex_rdy;
    bit [1:0] ex_sel;
    bit       ex_busy;
    bit [3:0] ex_v;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1, 0, 0, 8'h10, 4'hF, 0, 1, 0, 0, 4'b0000};
    tbl[1]  = '{1, 0, 0, 8'h11, 4'hF, 0, 1, 1, 0, 4'b0001};
    tbl[2]  = '{1, 0, 0, 8'h12, 4'hF, 0, 1, 2, 0, 4'b0010};
    tbl[3]  = '{1, 0, 0, 8'h13, 4'hF, 0, 1, 3, 0, 4'b0100};
    tbl[4]  = '{1, 0, 0, 8'h14, 4'hF, 0, 1, 0, 0, 4'b1000};
    tbl[5]  = '{0, 0, 0, 8'h00, 4'hF, 0, 1, 1, 0, 4'b0001};
    tbl[6]  = '{1, 1, 2, 8'hA0, 4'hB, 0, 1, 2, 0, 4'b0000};
    tbl[7]  = '{1, 1, 2, 8'hA1, 4'hB, 0, 0, 2, 0, 4'b0100};
    tbl[8]  = '{1, 1, 2, 8'hA1, 4'hB, 0, 0, 2, 0, 4'b0100};
    tbl[9]  = '{1, 1, 2, 8'hA1, 4'hF, 0, 1, 2, 0, 4'b0100};
    tbl[10] = '{1, 1, 1, 8'hA2, 4'hF, 0, 1, 1, 0, 4'b0100};
    tbl[11] = '{0, 0, 0, 8'h00, 4'hF, 0, 1, 1, 0, 4'b0010};

    rst_n = 1'b0; din = '0; in_valid = 0; in_dest = '0; mode = 0; flush = 0; rdy = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, round-robin streaming and directed stall/reload.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vld, tbl[i].md, tbl[i].dst, tbl[i].d, tbl[i].r, tbl[i].fl);
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].ex_rdy));
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].ex_sel));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ex_busy));
      chk($sformatf("tbl%0d_v", i), 32'({v3, v2, v1, v0}), 32'(tbl[i].ex_v));
      if (i == 7)  chk("y2_first", 32'(y2), 32'h A0);
      if (i == 10) chk("y2_reload", 32'(y2), 32'hA1);
      tick();
    end

    // Flush with lanes 0 and 3 stalled.
    drive(1, 1, 0, 8'hB0, 4'h6, 0); tick();
    drive(1, 1, 3, 8'hB3, 4'h6, 0); tick();
    drive(0, 0, 0, 8'h00, 4'h6, 1); chk("pre_flush_v", 32'({v3, v2, v1, v0}), 32'b1001); tick();
    drive(1, 0, 0, 8'hBF, 4'h6, 0); chk("drain_busy", 32'(busy), 1); chk("drain_ready", 32'(in_ready), 0); tick();
    drive(0, 0, 0, 8'h00, 4'hF, 0); chk("drain_busy2", 32'(busy), 1); tick();
    drive(0, 0, 0, 8'h00, 4'hF, 0); chk("drained_v", 32'({v3, v2, v1, v0}), 0); chk("drain_busy3", 32'(busy), 1); tick();
    drive(1, 0, 0, 8'hC0, 4'hF, 0); chk("rerun_busy", 32'(busy), 0); chk("rerun_sel", 32'(sel), 0);
    chk("rerun_ready", 32'(in_ready), 1); tick();
    drive(0, 0, 0, 8'h00, 4'hD, 0); chk("rerun_v0", 32'(v0), 1); chk("rerun_y0", 32'(y0), 32'hC0); tick();

    // Stalled lane 1 at ptr=1.
    drive(1, 1, 1, 8'hD1, 4'hD, 0); tick();
    drive(1, 0, 0, 8'hD2, 4'hD, 0);
    chk("stall_v1", 32'(v1), 1);
`ifdef DEMUX_SCHED_SKIP_EN
    chk("stall_ready", 32'(in_ready), 1); chk("stall_sel", 32'(sel), 2);
`else
    chk("stall_ready", 32'(in_ready), 0); chk("stall_sel", 32'(sel), 1);
`endif
    tick();
    drive(0, 0, 0, 8'h00, 4'hF, 0);
`ifdef DEMUX_SCHED_SKIP_EN
    chk("stall_ptr", 32'(sel), 3);
`else
    chk("stall_ptr", 32'(sel), 1);
`endif
    tick();

    // Asynchronous reset with lanes 1 and 2 holding words.
    drive(1, 1, 1, 8'hE1, 4'h9, 0); tick();
    drive(1, 1, 2, 8'hE2, 4'h9, 0); tick();
    drive(0, 0, 0, 8'h00, 4'h9, 0); chk("pre_rst_v", 32'({v3, v2, v1, v0}), 32'b0110);
    rst_n = 1'b0;
    #1;
    chk("rst_v", 32'({v3, v2, v1, v0}), 0);
    chk("rst_y", {y3, y2, y1, y0}, 0);
    chk("rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 8'h00, 4'hF, 0); chk("post_rst_ready", 32'(in_ready), 1); chk("post_rst_sel", 32'(sel), 0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit md = ($urandom_range(0, 9) < 5);
      bit [3:0] r;
      for (int l = 0; l < 4; l++) r[l] = ($urandom_range(0, 9) < 7);
      drive(bit'($urandom_range(0, 3) != 0), md, 2'($urandom_range(0, 3)), 8'($urandom),
            r, bit'($urandom_range(0, 24) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
